pb_conditioner: RTL and testbench
=================================

# pb_conditioner

Input-conditioning stage for the push-button bus that drives the synthesizer `top`. It synchronizes the raw `pb` pins from the breakout board, debounces each button against a shared sample tick, and emits clean levels, one-cycle press pulses, and a priority-encoded active key. It sits between the gpio pins and `top`; `top` consumes its outputs instead of the raw `pb` bus.

## Interface
- `NUM_PB`, default 21: number of buttons.
- `IDX_W`, default 5: key index width; must satisfy 2^IDX_W ≥ NUM_PB.
- `TICK_DIV`, default 10000: hwclk cycles per debounce sample tick; minimum 2.
- `STABLE_SAMPLES`, default 4: consecutive differing ticks required to commit a change; minimum 2.

Ports:
- `hwclk` input, 1 bit: system clock. All state is on its rising edge.
- `nrst` input, 1 bit: reset, asynchronous, active-low.
- `pb` input, NUM_PB bits: raw button levels, asynchronous to hwclk; 1 = pressed.
- `pb_clean` output, NUM_PB bits: debounced button levels.
- `pb_rise` output, NUM_PB bits: one-cycle pulse on each committed 0→1 transition of `pb_clean`.
- `key_idx` output, IDX_W bits: index of the lowest-numbered pressed button.
- `key_valid` output, 1 bit: at least one button is pressed.
- `key_strobe` output, 1 bit: one-cycle pulse whenever `{key_valid, key_idx}` changes.

## Operation
- **Reset.** `nrst` low clears the following immediately, independent of hwclk: synchronizer flops, tick counter, per-button sample counters, `pb_clean`, `pb_rise`, `key_idx`, `key_valid` and `key_strobe`. All outputs read 0.
- **Synchronizer.** Two flops per bit give `pb_sync`. No logic sits between the two stages.
- **Tick counter.**
  - Counts 0 to TICK_DIV-1, then wraps to 0.
  - `tick` is high for the single cycle the count equals TICK_DIV-1.
  - The counter runs freely and is not gated by button activity.
- **Per-button debounce.** Each button has a counter of width clog2(STABLE_SAMPLES). It only acts on `tick` cycles:
  - If `pb_sync[i]` equals `pb_clean[i]`, the counter clears to 0.
  - Else, if the counter equals STABLE_SAMPLES-1, `pb_clean[i]` toggles and the counter clears. This is the commit.
  - Else, the counter increments.
  - Any bounce back to the clean level before commit restarts the count, so a commit needs STABLE_SAMPLES consecutive differing ticks.
  - Press and release use the same rule.
- **`pb_rise[i]`.** Registered. It is high for exactly one cycle, the first cycle in which `pb_clean[i]` reads 1 after a commit. Release commits produce no pulse.
- **Encoder.**
  - `key_valid` registers OR(`pb_clean`).
  - `key_idx` registers the lowest i with `pb_clean[i]` = 1.
  - `key_idx` holds 0 when `key_valid` is 0.
- **`key_strobe`.** High for one cycle in the same cycle that a new `{key_valid, key_idx}` value first appears. It stays low if a commit leaves that pair unchanged, for example pressing a higher-index button while a lower one is held.
- **Simultaneous commits.** Several buttons committing on the same tick update together. The encoder sees them all in one cycle, so there is one strobe.

## Timing
- Raw edge to `pb_sync`: 2 cycles.
- `pb_sync` stable to `pb_clean` commit: between (STABLE_SAMPLES-1)·TICK_DIV+1 and STABLE_SAMPLES·TICK_DIV cycles, depending on tick phase.
- `pb_clean` to `key_idx` / `key_valid` / `key_strobe`: 1 cycle.
- `pb_rise` is coincident with the `pb_clean` rise.
- Strobes repeat at most once per tick.
- **Reset mid-operation:** a pending partial count is discarded. A button held through reset re-commits after a full debounce interval once `nrst` is released; `pb_rise` and `key_strobe` pulse again at that point.
- **Tick counter:** a new tick is never missed; wrap-around produces exactly one tick per TICK_DIV cycles.

## Test plan
All scenarios use TICK_DIV=4 and STABLE_SAMPLES=3.
- **Reset.** Hold `nrst` low with `pb`=all ones, then release. All outputs stay 0 through reset. After release, `pb_clean`=all ones within 2+12 cycles; `key_idx`=0, `key_valid`=1, and one `key_strobe` pulse follow.
- **Clean press of pb[7].** Expect `pb_clean[7]` to rise 9–12 cycles after `pb_sync[7]`, with `pb_rise[7]` high for 1 cycle. One cycle later, expect `key_idx`=7, `key_valid`=1 and `key_strobe`=1 for 1 cycle.
- **Bounce on pb[3].** Toggle pb[3] on every other tick for 20 ticks. `pb_clean[3]` must stay 0 throughout. Then hold it high for 3 ticks and expect a commit.
- **Priority.** Hold pb[12], then press pb[4]. Expect `key_idx` to go 12→4 with a strobe. Releasing pb[12] produces no strobe. Releasing pb[4] gives `key_valid`=0, `key_idx`=0 and a strobe.
- **Simultaneous press.** Press pb[20] and pb[0] in the same cycle. Both `pb_rise` bits pulse in the same cycle, followed by a single `key_strobe` with `key_idx`=0.
- **Reset mid-debounce.** Assert `nrst` low 2 ticks into a pb[5] press, then release. `pb_clean[5]` commits only after a full new debounce interval.

Source files
------------

// File: rtl/pb_conditioner.sv
// Push-button input conditioner: two-flop synchronizer, shared-tick debounce,
// rising-edge pulses and a lowest-index priority encoder with change strobe.
module pb_conditioner #(
  parameter int NUM_PB         = 21,
  parameter int IDX_W          = 5,
  parameter int TICK_DIV       = 10000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              hwclk,
  input  logic              nrst,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] pb_clean,
  output logic [NUM_PB-1:0] pb_rise,
  output logic [IDX_W-1:0]  key_idx,
  output logic              key_valid,
  output logic              key_strobe
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  COMMIT_CNT  = CNT_W'(STABLE_SAMPLES - 1);

  logic [NUM_PB-1:0] pb_meta;
  logic [NUM_PB-1:0] pb_sync;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic [CNT_W-1:0]  db_cnt   [NUM_PB];
  logic [CNT_W-1:0]  db_cnt_d [NUM_PB];
  logic [NUM_PB-1:0] clean_d;
  logic [NUM_PB-1:0] rise_d;

  logic [IDX_W-1:0]  idx_d;
  logic              valid_d;

  // Two-flop synchronizer; nothing sits between the stages.
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      pb_meta <= '0;
      pb_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old values
      // on the same edge; blocking here would collapse the chain into one flop.
      pb_meta <= pb;
      pb_sync <= pb_meta;
    end
  end

  // Free-running sample tick divider; tick is the last count of each period.
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Debounce next-state: on each tick, count consecutive differing samples and
  // toggle the clean level once the count reaches STABLE_SAMPLES.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    clean_d = pb_clean;
    rise_d  = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      db_cnt_d[i] = db_cnt[i];
    end
    if (tick) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (pb_sync[i] == pb_clean[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt[i] == COMMIT_CNT) begin
          clean_d[i]  = ~pb_clean[i];
          rise_d[i]   = ~pb_clean[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state, clean levels and the press pulse coincident with the rise.
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      pb_clean <= '0;
      pb_rise  <= '0;
      // NOTE: the sample counters are a small register array, not a RAM, so
      // they are reset explicitly to discard any partial count.
      for (int i = 0; i < NUM_PB; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      pb_clean <= clean_d;
      pb_rise  <= rise_d;
      for (int i = 0; i < NUM_PB; i++) begin
        db_cnt[i] <= db_cnt_d[i];
      end
    end
  end

  // Lowest-index priority encode of the clean levels; index is 0 when idle.
  always_comb begin
    valid_d = |pb_clean;
    idx_d   = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (pb_clean[i]) begin
        idx_d = IDX_W'(i);
      end
    end
  end

  // Register the encoder and pulse the strobe when the pair first changes.
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      key_idx    <= '0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      key_idx    <= idx_d;
      key_valid  <= valid_d;
      key_strobe <= ({valid_d, idx_d} != {key_valid, key_idx});
    end
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner (TICK_DIV=4, STABLE_SAMPLES=3).
// Expected encoder pairs are queued when stimulus is driven and popped by a
// monitor each time key_strobe fires.
module tb_pb_conditioner;

  localparam int NUM_PB = 21;
  localparam int IDX_W  = 5;
  localparam int TD     = 4;
  localparam int SS     = 3;
  localparam int MIN_N  = 2 + (SS - 1) * TD + 1;  // posedges from raw drive to commit
  localparam int MAX_N  = 2 + SS * TD;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } key_t;

  logic              hwclk;
  logic              nrst;
  logic [NUM_PB-1:0] pb;
  logic [NUM_PB-1:0] pb_clean;
  logic [NUM_PB-1:0] pb_rise;
  logic [IDX_W-1:0]  key_idx;
  logic              key_valid;
  logic              key_strobe;

  int   vectors;
  int   miscompares;
  key_t exp_q[$];

  pb_conditioner #(
    .NUM_PB(NUM_PB), .IDX_W(IDX_W), .TICK_DIV(TD), .STABLE_SAMPLES(SS)
  ) dut (
    .hwclk(hwclk), .nrst(nrst), .pb(pb), .pb_clean(pb_clean), .pb_rise(pb_rise),
    .key_idx(key_idx), .key_valid(key_valid), .key_strobe(key_strobe)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  function automatic key_t mk(input logic v, input int idx);
    key_t k;
    k.valid = v;
    k.idx   = IDX_W'(idx);
    return k;
  endfunction

  // Wait for pb_clean[b] to reach level, counting posedges; bounded by budget.
  task automatic wait_bit(input int b, input logic level, input int budget, output int n);
    n = 0;
    do begin
      @(posedge hwclk); #1;
      n++;
    end while (pb_clean[b] !== level && n < budget);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge hwclk); #1;
    end
  endtask

  task automatic test_reset;
    int n;
    nrst = 1'b0;
    pb   = '1;
    for (int c = 0; c < 4; c++) begin
      @(posedge hwclk); #1;
      vectors++;
      if ({pb_clean, pb_rise, key_idx, key_valid, key_strobe} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: clean=%h rise=%h idx=%0d valid=%b strobe=%b, required all 0",
                 pb_clean, pb_rise, key_idx, key_valid, key_strobe);
      end
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 0));
    nrst = 1'b1;
    n = 0;
    do begin
      @(posedge hwclk); #1;
      n++;
    end while (pb_clean !== '1 && n < 20);
    vectors++;
    if (pb_clean !== '1 || n > MAX_N) begin
      miscompares++;
      $display("FAIL reset_commit: clean=%h after %0d cycles, required all ones within %0d",
               pb_clean, n, MAX_N);
    end
    @(posedge hwclk); #1;
    vectors++;
    if (key_valid !== 1'b1 || key_idx !== '0 || key_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_encoder: valid=%b idx=%0d strobe=%b, required 1/0/1",
               key_valid, key_idx, key_strobe);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b0, 0));
    pb = '0;
    n = 0;
    do begin
      @(posedge hwclk); #1;
      n++;
    end while (pb_clean !== '0 && n < 20);
    vectors++;
    if (pb_clean !== '0) begin
      miscompares++;
      $display("FAIL reset_release: clean=%h, required 0", pb_clean);
    end
    idle(3);
  endtask

  task automatic test_press7;
    int n;
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 7));
    pb[7] = 1'b1;
    wait_bit(7, 1'b1, 20, n);
    vectors++;
    if (pb_clean[7] !== 1'b1 || n < MIN_N || n > MAX_N) begin
      miscompares++;
      $display("FAIL press7_latency: clean7=%b after %0d cycles, required 1 within %0d..%0d",
               pb_clean[7], n, MIN_N, MAX_N);
    end
    vectors++;
    if (pb_rise !== (NUM_PB'(1) << 7)) begin
      miscompares++;
      $display("FAIL press7_rise: rise=%h, required %h", pb_rise, NUM_PB'(1) << 7);
    end
    @(posedge hwclk); #1;
    vectors++;
    if (pb_rise !== '0 || key_idx !== 5'd7 || key_valid !== 1'b1 || key_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL press7_encoder: rise=%h idx=%0d valid=%b strobe=%b, required 0/7/1/1",
               pb_rise, key_idx, key_valid, key_strobe);
    end
    @(posedge hwclk); #1;
    vectors++;
    if (key_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL press7_strobe_width: strobe=%b, required 0", key_strobe);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b0, 0));
    pb[7] = 1'b0;
    wait_bit(7, 1'b0, 20, n);
    vectors++;
    if (pb_clean[7] !== 1'b0 || pb_rise !== '0) begin
      miscompares++;
      $display("FAIL press7_release: clean7=%b rise=%h, required 0/0", pb_clean[7], pb_rise);
    end
    idle(3);
  endtask

  task automatic test_bounce;
    int  n;
    bit  seen;
    seen = 1'b0;
    for (int ph = 0; ph < 10; ph++) begin
      @(negedge hwclk);
      pb[3] = ~pb[3];
      for (int c = 0; c < 2 * TD; c++) begin
        @(posedge hwclk); #1;
        if (pb_clean[3] !== 1'b0) seen = 1'b1;
      end
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL bounce_hold: clean3 went high during bounce, required 0 throughout");
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 3));
    pb[3] = 1'b1;
    wait_bit(3, 1'b1, 20, n);
    vectors++;
    if (pb_clean[3] !== 1'b1 || n > MAX_N) begin
      miscompares++;
      $display("FAIL bounce_commit: clean3=%b after %0d cycles, required 1 within %0d",
               pb_clean[3], n, MAX_N);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b0, 0));
    pb[3] = 1'b0;
    wait_bit(3, 1'b0, 20, n);
    idle(3);
  endtask

  task automatic test_priority;
    int n;
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 12));
    pb[12] = 1'b1;
    wait_bit(12, 1'b1, 20, n);
    idle(2);
    vectors++;
    if (key_idx !== 5'd12 || key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_first: idx=%0d valid=%b, required 12/1", key_idx, key_valid);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 4));
    pb[4] = 1'b1;
    wait_bit(4, 1'b1, 20, n);
    @(posedge hwclk); #1;
    vectors++;
    if (key_idx !== 5'd4 || key_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_switch: idx=%0d strobe=%b, required 4/1", key_idx, key_strobe);
    end
    @(negedge hwclk);
    pb[12] = 1'b0;
    wait_bit(12, 1'b0, 20, n);
    idle(2);
    vectors++;
    if (key_idx !== 5'd4 || key_valid !== 1'b1 || pb_clean[12] !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_hold: idx=%0d valid=%b clean12=%b, required 4/1/0",
               key_idx, key_valid, pb_clean[12]);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b0, 0));
    pb[4] = 1'b0;
    wait_bit(4, 1'b0, 20, n);
    @(posedge hwclk); #1;
    vectors++;
    if (key_valid !== 1'b0 || key_idx !== '0 || key_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_release: valid=%b idx=%0d strobe=%b, required 0/0/1",
               key_valid, key_idx, key_strobe);
    end
    idle(3);
  endtask

  task automatic test_simultaneous;
    int                n;
    logic [NUM_PB-1:0] both;
    both = (NUM_PB'(1) << 20) | NUM_PB'(1);
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 0));
    pb = both;
    wait_bit(0, 1'b1, 20, n);
    vectors++;
    if (pb_rise !== both || pb_clean !== both) begin
      miscompares++;
      $display("FAIL simul_rise: rise=%h clean=%h, required %h/%h", pb_rise, pb_clean, both, both);
    end
    @(posedge hwclk); #1;
    vectors++;
    if (key_idx !== '0 || key_valid !== 1'b1 || key_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_encoder: idx=%0d valid=%b strobe=%b, required 0/1/1",
               key_idx, key_valid, key_strobe);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b0, 0));
    pb = '0;
    wait_bit(20, 1'b0, 20, n);
    idle(3);
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge hwclk);
    pb[5] = 1'b1;
    idle(2 * TD);
    #2;
    nrst = 1'b0;
    #1;
    vectors++;
    if ({pb_clean, pb_rise, key_idx, key_valid, key_strobe} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: clean=%h rise=%h idx=%0d valid=%b strobe=%b, required all 0",
               pb_clean, pb_rise, key_idx, key_valid, key_strobe);
    end
    idle(3);
    @(negedge hwclk);
    exp_q.push_back(mk(1'b1, 5));
    nrst = 1'b1;
    wait_bit(5, 1'b1, 20, n);
    vectors++;
    if (pb_clean[5] !== 1'b1 || n < MIN_N || n > MAX_N) begin
      miscompares++;
      $display("FAIL midreset_commit: clean5=%b after %0d cycles, required 1 within %0d..%0d",
               pb_clean[5], n, MIN_N, MAX_N);
    end
    vectors++;
    if (pb_rise[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_rise: rise5=%b, required 1", pb_rise[5]);
    end
    @(negedge hwclk);
    exp_q.push_back(mk(1'b0, 0));
    pb[5] = 1'b0;
    wait_bit(5, 1'b0, 20, n);
    idle(3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nrst        = 1'b0;
    pb          = '0;

    fork
      // Scoreboard monitor: every strobe must match the next queued pair.
      forever begin
        @(negedge hwclk);
        if (key_strobe === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL strobe_unexpected: valid=%b idx=%0d, required no strobe",
                     key_valid, key_idx);
          end else begin
            key_t e;
            e = exp_q.pop_front();
            if ({key_valid, key_idx} !== e) begin
              miscompares++;
              $display("FAIL strobe_value: valid=%b idx=%0d, required valid=%b idx=%0d",
                       key_valid, key_idx, e.valid, e.idx);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_press7();
    test_bounce();
    test_priority();
    test_simultaneous();
    test_reset_mid();

    idle(4);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL strobe_missing: %0d expected strobes never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
